// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: instruction classes, producer latencies and the
// default MDU latency used by the hazard scoreboard.
package pipe_pkg;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LOAD = 2'b01;
  localparam logic [1:0] CLS_MDU  = 2'b10;

  localparam int LAT_ALU     = 0;
  localparam int LAT_LOAD    = 1;
  localparam int MDU_LAT_DEF = 4;

  // Cycles from issue until the result of this class is forwardable.
  // The reserved class encoding behaves like an ALU op.
  function automatic logic [7:0] lat_of(input logic [1:0] cls,
                                        input int mdu_lat = MDU_LAT_DEF);
    case (cls)
      CLS_LOAD: lat_of = 8'(LAT_LOAD);
      CLS_MDU:  lat_of = 8'(mdu_lat);
      default:  lat_of = 8'(LAT_ALU);
    endcase
  endfunction

endpackage

// File: rtl/scb_counter.sv
// Loadable saturating down-counter with asynchronous active-low clear and a
// nonzero flag; one per architectural register plus one for the MDU.
module scb_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          nz
);

  assign nz = |count;

  // A load overrides the decrement; an idle counter stays at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (nz)
      count <= count - CW'(1);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: per-register forwardability countdowns, RAW/WAW and
// MDU structural stalls. Define SCB_STATS_EN to add the stall_count output.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_we,
  input  logic [1:0]  id_class,
  input  logic        flush,
  output logic        stall,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        issue,
  output logic        mdu_busy
`ifdef SCB_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  logic [31:0][CW-1:0] cnt;
  logic [31:0]         nz;
  logic [CW-1:0]       lat_id;
  logic                mdu_nz;
  logic                raw;
  logic                waw;
  logic                strct;
  logic                hazard;

  assign lat_id = CW'(lat_of(id_class, MDU_LAT));

  // r0 is never a producer, so its slot is tied off instead of instantiated.
  assign cnt[0] = '0;
  assign nz[0]  = 1'b0;

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    scb_counter #(.CW(CW)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (issue && id_we && (id_rd == 5'(gi))),
      .load_val (lat_id),
      .count    (cnt[gi]),
      .nz       (nz[gi])
    );
  end

  scb_counter #(.CW(CW)) u_mdu (
    .clk      (clk),
    .rst      (rst),
    .load     (issue && (id_class == CLS_MDU)),
    .load_val (CW'(MDU_LAT)),
    .count    (),
    .nz       (mdu_nz)
  );

  assign raw    = (id_use_rs1 && nz[id_rs1]) || (id_use_rs2 && nz[id_rs2]);
  // A younger writer may only issue once it can no longer finish before the older one.
  assign waw    = id_we && (id_rd != 5'd0) && (cnt[id_rd] > lat_id);
  assign strct  = (id_class == CLS_MDU) && mdu_nz;
  assign hazard = raw || waw || strct;

  // Reset forces the pipeline into a bubble-insertion, free-running state.
  assign stall       = rst && id_valid && !flush && hazard;
  assign issue       = rst && id_valid && !flush && !hazard;
  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = !rst || stall || flush || !id_valid;
  assign mdu_busy    = mdu_nz;

`ifdef SCB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_count <= '0;
    else if (stall && (stall_count != 32'hFFFF_FFFF))
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule
